// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: prescaled hh:mm:ss clock with day/month calendar, checked field writes and 12/24h view.
// Alarm registers and the alarm_hit pulse exist only when RTC_ALARM_EN is defined.
module rtc_calendar_core #(
  parameter int TICK_DIV = 65536,
  parameter int DIV_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       mode12,
  input  logic       set_valid,
  input  logic [2:0] set_sel,
  input  logic [5:0] set_value,
  output logic       set_err,
  output logic       tick,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic       alarm_hit
);

  logic [DIV_W-1:0] presc;
  logic             wr_ok, wr_acc, tick_adv;
  logic             sec_wrap, min_wrap, hour_wrap, day_wrap, carry_day;
  logic [5:0]       nxt_sec, nxt_min;
  logic [4:0]       nxt_hour, nxt_day, new_len;
  logic [3:0]       nxt_month;

`ifdef RTC_ALARM_EN
  logic [4:0]       alarm_hour;
  logic [5:0]       alarm_min;
`endif

  function automatic logic [4:0] month_len(input logic [3:0] m);
    case (m)
      4'd2:                     return 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  assign tick     = run && (presc == DIV_W'(TICK_DIV - 1));
  assign new_len  = month_len(set_value[3:0]);
  assign wr_acc   = set_valid && wr_ok;
  // An accepted write owns the fields this edge; the coincident tick only pulses.
  assign tick_adv = tick && !wr_acc;

  always_comb begin
    wr_ok = 1'b0;
    case (set_sel)
      3'd0, 3'd1: wr_ok = (set_value <= 6'd59);
      3'd2:       wr_ok = (set_value <= 6'd23);
      3'd3:       wr_ok = (set_value != 6'd0) && (set_value <= {1'b0, month_len(month)});
      3'd4:       wr_ok = (set_value != 6'd0) && (set_value <= 6'd12);
`ifdef RTC_ALARM_EN
      3'd5:       wr_ok = (set_value <= 6'd23);
      3'd6:       wr_ok = (set_value <= 6'd59);
`endif
      default:    wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    sec_wrap  = (sec == 6'd59);
    min_wrap  = (min == 6'd59);
    hour_wrap = (hour == 5'd23);
    day_wrap  = (day == month_len(month));
    carry_day = sec_wrap && min_wrap && hour_wrap;
    nxt_sec   = sec_wrap ? 6'd0 : sec + 6'd1;
    nxt_min   = min;
    nxt_hour  = hour;
    nxt_day   = day;
    nxt_month = month;
    if (sec_wrap) nxt_min = min_wrap ? 6'd0 : min + 6'd1;
    if (sec_wrap && min_wrap) nxt_hour = hour_wrap ? 5'd0 : hour + 5'd1;
    if (carry_day) nxt_day = day_wrap ? 5'd1 : day + 5'd1;
    if (carry_day && day_wrap) nxt_month = (month == 4'd12) ? 4'd1 : month + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc   <= '0;
      sec     <= 6'd0;
      min     <= 6'd0;
      hour    <= 5'd0;
      day     <= 5'd1;
      month   <= 4'd1;
      set_err <= 1'b0;
    end else begin
      set_err <= set_valid && !wr_ok;
      if (run) presc <= tick ? '0 : presc + DIV_W'(1);
      if (wr_acc) begin
        case (set_sel)
          3'd0: begin
            sec   <= set_value;
            presc <= '0;
          end
          3'd1: min  <= set_value;
          3'd2: hour <= set_value[4:0];
          3'd3: day  <= set_value[4:0];
          3'd4: begin
            month <= set_value[3:0];
            if (day > new_len) day <= new_len;
          end
          default: ;
        endcase
      end else if (tick_adv) begin
        sec   <= nxt_sec;
        min   <= nxt_min;
        hour  <= nxt_hour;
        day   <= nxt_day;
        month <= nxt_month;
      end
    end
  end

`ifdef RTC_ALARM_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      alarm_hit  <= 1'b0;
    end else begin
      // Only a tick landing on hh:mm:00 fires; writing the matching time does not.
      alarm_hit <= tick_adv && (nxt_sec == 6'd0) && (nxt_min == alarm_min) && (nxt_hour == alarm_hour);
      if (wr_acc && set_sel == 3'd5) alarm_hour <= set_value[4:0];
      if (wr_acc && set_sel == 3'd6) alarm_min  <= set_value;
    end
  end
`else
  assign alarm_hit = 1'b0;
`endif

  always_comb begin
    hour_disp = hour;
    pm        = 1'b0;
    if (mode12) begin
      pm = (hour >= 5'd12);
      if (hour == 5'd0)      hour_disp = 5'd12;
      else if (hour > 5'd12) hour_disp = hour - 5'd12;
    end
  end

endmodule
